alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width in bits (legal: 8..64, even).
REQ-002 SHALL have port clk  input  1  single rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  request accepted when in_valid&&in_ready.
REQ-006 SHALL have port alu_op  input  2  00 add, 01 sub, 10 R-type decode, 11 LUI pass-through.
REQ-007 SHALL have port funct3  input  3  R-type function.
REQ-008 SHALL have port funct7  input  7  R-type modifier.
REQ-009 SHALL have port op_a  input  XLEN  operand A.
REQ-010 SHALL have port op_b  input  XLEN  operand B / immediate.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port result  output  XLEN  registered result.
REQ-014 SHALL have port illegal  output  1  registered; request decoded to no operation.

Function
REQ-015 SHALL implement FSM IDLE, CALC, DONE; in_ready=1 only in IDLE.
REQ-016 SHALL capture alu_op/funct3/funct7/op_a/op_b only on accepted handshake; inputs ignored otherwise.
REQ-017 SHALL decode: 00 ADD; 01 SUB; 11 result=op_b; 10 with funct7=0000000 -> ADD,SLL,SLT,SLTU,XOR,SRL,OR,AND by funct3; funct7=0100000 -> SUB (f3=000), SRA (f3=101); funct7=0000001 -> M-extension.
REQ-018 SHALL flag illegal=1, result=0 for any other 10-encoding; transaction still completes via DONE.
REQ-019 SHALL complete single-cycle ops IDLE->DONE: out_valid high exactly 1 cycle after acceptance.
REQ-020 SHALL run M ops IDLE->CALC->DONE: MUL/MULH/MULHSU/MULHU via shift-add, DIV/DIVU/REM/REMU via restoring division, exactly XLEN CALC cycles; out_valid high XLEN+1 cycles after acceptance.
REQ-021 SHALL use shift amount op_b[log2(XLEN)-1:0]; SLT/SLTU produce 0 or 1 zero-extended.
REQ-022 SHALL, on divide by zero, return quotient all-ones and remainder op_a, taking full XLEN cycles.
REQ-023 SHALL, on signed overflow (op_a=-2^(XLEN-1), op_b=-1), return quotient op_a, remainder 0.
REQ-024 SHALL hold result, illegal, out_valid stable in DONE until out_ready=1; then DONE->IDLE next edge.
REQ-025 SHALL not accept a new request in the cycle DONE is left (one idle cycle between transactions).
REQ-026 SHALL wrap ADD/SUB modulo 2^XLEN with no overflow flag.

Reset
REQ-027 SHALL, on rst_n low at any time (incl. mid-CALC), force state IDLE, out_valid=0, result=0, illegal=0, iteration counter=0; in_ready=1 from first edge after release.
REQ-028 SHALL discard an in-flight operation on reset; no result is produced for it.

Configuration
REQ-029 SHALL honour macro ALU_MULDIV_EN: defined -> REQ-020..023 implemented; undefined -> funct7=0000001 treated as illegal per REQ-018, CALC state and sub-module absent.

Structure
REQ-030 SHALL place 5-bit operation codes (OPADD, OPSUB, OPAND, OPOR, OPXOR, OPSLT, OPSLTU, OPSLL, OPSRL, OPSRA, OPLUI, OPMUL..OPREMU), alu_op values, funct3/funct7 constants, and FSM state typedef in shared package alu_pkg.
REQ-031 SHALL implement iterative multiply/divide in sub-module muldiv_iter (start/done handshake, parameter XLEN).

Verification
REQ-032 SHALL cover: alu_op=10,f3=000,f7=0100000,a=5,b=7 -> result=0xFFFFFFFE, out_valid at acceptance+1.
REQ-033 SHALL cover: f7=0000001,f3=100 (DIV), a=0x80000000,b=0xFFFFFFFF -> 0x80000000 at acceptance+33; REM same operands -> 0.
REQ-034 SHALL cover: DIVU a=0x1234,b=0 -> 0xFFFFFFFF; REMU -> 0x1234; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE.
REQ-035 SHALL cover: out_ready held low 5 cycles in DONE -> result/out_valid stable, in_ready=0 throughout.
REQ-036 SHALL cover: rst_n low at CALC cycle 10 -> out_valid=0, in_ready=1 after release, no stale result.
REQ-037 SHALL cover: ALU_MULDIV_EN undefined, MUL request -> illegal=1, result=0, out_valid at acceptance+1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, decode constants, FSM states and instruction decode for alu_exec_unit.
// Macro ALU_MULDIV_EN enables the M-extension encodings and the CALC state.
package alu_pkg;

  typedef enum logic [4:0] {
    OPADD, OPSUB, OPAND, OPOR, OPXOR, OPSLT, OPSLTU, OPSLL, OPSRL, OPSRA, OPLUI,
    OPMUL, OPMULH, OPMULHSU, OPMULHU, OPDIV, OPDIVU, OPREM, OPREMU, OPILL
  } op_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_LUI   = 2'b11;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    S_IDLE,
`ifdef ALU_MULDIV_EN
    S_CALC,
`endif
    S_DONE
  } state_e;

  function automatic logic isMulDiv(input op_e op);
    return op inside {OPMUL, OPMULH, OPMULHSU, OPMULHU, OPDIV, OPDIVU, OPREM, OPREMU};
  endfunction

  // Anything not matched falls through to OPILL, which completes with result 0.
  function automatic op_e decodeOp(input logic [1:0] aluOp, input logic [2:0] f3,
                                   input logic [6:0] f7);
    op_e op;
    op = OPILL;
    case (aluOp)
      ALUOP_ADD: op = OPADD;
      ALUOP_SUB: op = OPSUB;
      ALUOP_LUI: op = OPLUI;
      default: begin
        if (f7 == F7_BASE) begin
          case (f3)
            F3_ADD:  op = OPADD;
            F3_SLL:  op = OPSLL;
            F3_SLT:  op = OPSLT;
            F3_SLTU: op = OPSLTU;
            F3_XOR:  op = OPXOR;
            F3_SRL:  op = OPSRL;
            F3_OR:   op = OPOR;
            default: op = OPAND;
          endcase
        end else if (f7 == F7_ALT) begin
          if (f3 == F3_ADD) op = OPSUB;
          else if (f3 == F3_SRL) op = OPSRA;
        end
`ifdef ALU_MULDIV_EN
        else if (f7 == F7_MULDIV) begin
          case (f3)
            3'd0:    op = OPMUL;
            3'd1:    op = OPMULH;
            3'd2:    op = OPMULHSU;
            3'd3:    op = OPMULHU;
            3'd4:    op = OPDIV;
            3'd5:    op = OPDIVU;
            3'd6:    op = OPREM;
            default: op = OPREMU;
          endcase
        end
`endif
      end
    endcase
    return op;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply (shift-add) and restoring divide, one bit per cycle for XLEN cycles.
// Instantiated by alu_exec_unit only when ALU_MULDIV_EN is defined.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  op_e             op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int CW = $clog2(XLEN);

  logic            busy_q;
  logic [CW-1:0]   cnt_q;
  op_e             op_q;
  logic            neg_q;
  logic [XLEN-1:0] hi_q, lo_q, dvs_q;
  logic [XLEN-1:0] hi_d, lo_d;
  logic            sa, sb, isMul;
  logic [XLEN-1:0] magA, magB;
  logic [XLEN:0]   sum, remSh;
  logic [2*XLEN-1:0] prod;

  // Both algorithms run on magnitudes; the sign is reapplied to the final value.
  always_comb begin
    sa   = (op_i inside {OPMULH, OPMULHSU, OPDIV, OPREM}) && a_i[XLEN-1];
    sb   = (op_i inside {OPMULH, OPDIV, OPREM}) && b_i[XLEN-1];
    magA = sa ? -a_i : a_i;
    magB = sb ? -b_i : b_i;
  end

  always_comb begin
    isMul = op_q inside {OPMUL, OPMULH, OPMULHSU, OPMULHU};
    sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
    remSh = {hi_q, lo_q[XLEN-1]};
    if (isMul) begin
      hi_d = sum[XLEN:1];
      lo_d = {sum[0], lo_q[XLEN-1:1]};
    end else if (remSh >= {1'b0, dvs_q}) begin
      hi_d = remSh[XLEN-1:0] - dvs_q;
      lo_d = {lo_q[XLEN-2:0], 1'b1};
    end else begin
      hi_d = remSh[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], 1'b0};
    end
    prod = neg_q ? -{hi_d, lo_d} : {hi_d, lo_d};
    case (op_q)
      OPMUL:                     result_o = prod[XLEN-1:0];
      OPMULH, OPMULHSU, OPMULHU: result_o = prod[2*XLEN-1:XLEN];
      OPDIV, OPDIVU:             result_o = neg_q ? -lo_d : lo_d;
      default:                   result_o = neg_q ? -hi_d : hi_d;
    endcase
    done_o = busy_q && (cnt_q == CW'(XLEN - 1));
  end

  // A zero divisor needs no special path: every step subtracts, giving all-ones and op_a.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      op_q   <= OPMUL;
      neg_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      dvs_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      op_q   <= op_i;
      hi_q   <= '0;
      if (op_i inside {OPMUL, OPMULH, OPMULHSU, OPMULHU}) begin
        lo_q  <= magB;
        dvs_q <= magA;
        neg_q <= sa ^ sb;
      end else begin
        lo_q  <= magA;
        dvs_q <= magB;
        neg_q <= (op_i inside {OPDIV, OPDIVU}) ? ((sa ^ sb) && (b_i != '0)) : sa;
      end
    end else if (busy_q) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit with valid/ready request and result handshakes (IDLE/CALC/DONE).
// Define ALU_MULDIV_EN to add the iterative M-extension path through muldiv_iter.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);
  localparam int SHW = $clog2(XLEN);

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            illegal_q, illegal_d;
  logic            accept;
  op_e             opDec;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] aluRes;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign illegal   = illegal_q;
  assign accept    = in_valid && in_ready;
  assign opDec     = decodeOp(alu_op, funct3, funct7);
  assign shamt     = op_b[SHW-1:0];

  always_comb begin
    aluRes = '0;
    case (opDec)
      OPADD:   aluRes = op_a + op_b;
      OPSUB:   aluRes = op_a - op_b;
      OPAND:   aluRes = op_a & op_b;
      OPOR:    aluRes = op_a | op_b;
      OPXOR:   aluRes = op_a ^ op_b;
      OPSLT:   aluRes = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OPSLTU:  aluRes = {{(XLEN-1){1'b0}}, op_a < op_b};
      OPSLL:   aluRes = op_a << shamt;
      OPSRL:   aluRes = op_a >> shamt;
      OPSRA:   aluRes = XLEN'($signed(op_a) >>> shamt);
      OPLUI:   aluRes = op_b;
      default: aluRes = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  logic            mdDone;
  logic [XLEN-1:0] mdResult;

  muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (accept && isMulDiv(opDec)),
    .op_i     (opDec),
    .a_i      (op_a),
    .b_i      (op_b),
    .done_o   (mdDone),
    .result_o (mdResult)
  );
`endif

  // Single-cycle results are latched at acceptance; M ops latch when the iterator finishes.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          result_d  = aluRes;
          illegal_d = (opDec == OPILL);
          state_d   = S_DONE;
`ifdef ALU_MULDIV_EN
          if (isMulDiv(opDec)) state_d = S_CALC;
`endif
        end
      end
`ifdef ALU_MULDIV_EN
      S_CALC: begin
        if (mdDone) begin
          result_d = mdResult;
          state_d  = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized and directed bench for alu_exec_unit against an arithmetic reference model.
// Expectations follow the build: ALU_MULDIV_EN defined enables the M-extension model.
module tb_alu_exec_unit;
  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct3    (funct3),
    .funct7    (funct7),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: computed directly from the instruction semantics with 64-bit arithmetic.
  function automatic void refModel(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] res, output logic ill, output int lat);
    longint sa, sb;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = 32'd0;
    ill = 1'b0;
    lat = 1;
    if (op == 2'b00) res = a + b;
    else if (op == 2'b01) res = a - b;
    else if (op == 2'b11) res = b;
    else if (f7 == 7'h00) begin
      case (f3)
        3'd0: res = a + b;
        3'd1: res = a << b[4:0];
        3'd2: res = (sa < sb) ? 32'd1 : 32'd0;
        3'd3: res = (a < b) ? 32'd1 : 32'd0;
        3'd4: res = a ^ b;
        3'd5: res = a >> b[4:0];
        3'd6: res = a | b;
        default: res = a & b;
      endcase
    end else if (f7 == 7'h20 && f3 == 3'd0) res = a - b;
    else if (f7 == 7'h20 && f3 == 3'd5) res = 32'(sa >>> b[4:0]);
`ifdef ALU_MULDIV_EN
    else if (f7 == 7'h01) begin
      lat = 33;
      case (f3)
        3'd0: begin p = ua * ub; res = p[31:0]; end
        3'd1: begin p = 64'(sa * sb); res = p[63:32]; end
        3'd2: begin p = 64'(sa * longint'(ub)); res = p[63:32]; end
        3'd3: begin p = ua * ub; res = p[63:32]; end
        3'd4: res = (b == 0) ? 32'hFFFF_FFFF :
                    (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb);
        3'd5: res = (b == 0) ? 32'hFFFF_FFFF : a / b;
        3'd6: res = (b == 0) ? a :
                    (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
        default: res = (b == 0) ? a : a % b;
      endcase
    end
`endif
    else ill = 1'b1;
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic applyStimulus(input string name, input logic [1:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                               input int hold);
    logic [31:0] expRes;
    logic        expIll;
    int          expLat;
    int          n;
    logic        stable;
    refModel(op, f3, f7, a, b, expRes, expIll, expLat);
    @(negedge clk);
    alu_op   = op;
    funct3   = f3;
    funct7   = f7;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    checkOutput({name, ".in_ready_idle"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    alu_op   = 2'($urandom);
    funct3   = 3'($urandom);
    funct7   = 7'($urandom);
    op_a     = $urandom;
    op_b     = $urandom;
    n = 1;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({name, ".latency"}, n, expLat);
    checkOutput({name, ".result"}, result, expRes);
    checkOutput({name, ".illegal"}, illegal, expIll);
    checkOutput({name, ".in_ready_busy"}, in_ready, 0);
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== expRes || illegal !== expIll)
        stable = 1'b0;
    end
    if (hold > 0) checkOutput({name, ".hold_stable"}, stable, 1);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({name, ".out_valid_drop"}, out_valid, 0);
    checkOutput({name, ".in_ready_back"}, in_ready, 1);
  endtask

  // Reset lands mid-CALC with the M path built, otherwise on a finished illegal request.
  task automatic resetInFlight();
    @(negedge clk);
    alu_op   = 2'b10;
    funct3   = 3'd4;
    funct7   = 7'h01;
    op_a     = 32'd1000;
    op_b     = 32'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid.out_valid", out_valid, 0);
    checkOutput("rst_mid.in_ready", in_ready, 1);
    checkOutput("rst_mid.result", result, 0);
    checkOutput("rst_mid.illegal", illegal, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("rst_mid.no_stale_valid", out_valid, 0);
    checkOutput("rst_mid.ready_after", in_ready, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alu_op    = 2'b00;
    funct3    = 3'd0;
    funct7    = 7'd0;
    op_a      = 32'd0;
    op_b      = 32'd0;
    #1;
    checkOutput("reset.out_valid", out_valid, 0);
    checkOutput("reset.result", result, 0);
    checkOutput("reset.illegal", illegal, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset.in_ready", in_ready, 1);

    applyStimulus("sub_r",      2'b10, 3'd0, 7'h20, 32'd5, 32'd7, 0);
    checkOutput("sub_r.const", dut.result_q, 32'hFFFF_FFFE);
    applyStimulus("add_wrap",   2'b00, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'd1, 0);
    applyStimulus("sub_wrap",   2'b01, 3'd0, 7'h00, 32'd0, 32'd1, 0);
    applyStimulus("lui",        2'b11, 3'd3, 7'h55, 32'h1234_5678, 32'hABCD_E000, 0);
    applyStimulus("sra",        2'b10, 3'd5, 7'h20, 32'h8000_0000, 32'h0000_0024, 0);
    applyStimulus("sll",        2'b10, 3'd1, 7'h00, 32'h0000_0003, 32'hFFFF_FFE1, 0);
    applyStimulus("slt",        2'b10, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'd1, 0);
    applyStimulus("sltu",       2'b10, 3'd3, 7'h00, 32'hFFFF_FFFF, 32'd1, 0);
    applyStimulus("ill_alt",    2'b10, 3'd1, 7'h20, 32'd9, 32'd9, 0);
    applyStimulus("ill_f7",     2'b10, 3'd0, 7'h7F, 32'd9, 32'd9, 0);
    applyStimulus("div_ovf",    2'b10, 3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus("rem_ovf",    2'b10, 3'd6, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus("divu_zero",  2'b10, 3'd5, 7'h01, 32'h0000_1234, 32'd0, 0);
    applyStimulus("remu_zero",  2'b10, 3'd7, 7'h01, 32'h0000_1234, 32'd0, 0);
    applyStimulus("div_zero",   2'b10, 3'd4, 7'h01, 32'hFFFF_FF00, 32'd0, 0);
    applyStimulus("rem_zero",   2'b10, 3'd6, 7'h01, 32'hFFFF_FF00, 32'd0, 0);
    applyStimulus("mulhu",      2'b10, 3'd3, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    applyStimulus("mul",        2'b10, 3'd0, 7'h01, 32'hFFFF_FFFD, 32'd7, 0);
    applyStimulus("mulh",       2'b10, 3'd1, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus("mulhsu",     2'b10, 3'd2, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    applyStimulus("rem_neg",    2'b10, 3'd6, 7'h01, 32'hFFFF_FFF9, 32'd2, 0);
    applyStimulus("hold_done",  2'b10, 3'd7, 7'h00, 32'hF0F0_1234, 32'h0FF0_FFFF, 5);

    resetInFlight();
    applyStimulus("post_rst",   2'b10, 3'd6, 7'h00, 32'h0000_00F0, 32'h0000_000F, 0);

    for (int t = 0; t < 80; t++) begin
      logic [6:0] f7;
      case ($urandom_range(0, 3))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        2:       f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      applyStimulus($sformatf("rand%0d", t), 2'($urandom_range(0, 3)), 3'($urandom), f7,
                    pickOperand(), pickOperand(), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
